// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: state encoding,
// iteration counts and the signed-overflow constant.
package multdiv_pkg;

   localparam int WIDTH     = 32;
   localparam int MUL_ITERS = WIDTH / 2;
   localparam int DIV_ITERS = WIDTH;
   localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value);
      return value[WIDTH-1] ? -value : value;
   endfunction

endpackage

// File: rtl/multdiv_booth_step.sv
// One radix-4 Booth iteration: add 0, +-M or +-2M to the upper partial product,
// then arithmetic-shift the whole register right by two.
module booth_step
   import multdiv_pkg::*;
(
   input  logic [2:0]         window,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [2*WIDTH:0]   partial,
   output logic [2*WIDTH+2:0] partialNext
);

   // The upper accumulator carries two guard bits so that +-2M never overflows.
   logic signed [WIDTH+1:0] upper;
   logic signed [WIDTH+1:0] mExt;
   logic signed [WIDTH+1:0] addend;
   logic signed [WIDTH+1:0] sum;

   always_comb begin
      upper  = partial[2*WIDTH:WIDTH-1];
      mExt   = {{2{mcand[WIDTH-1]}}, mcand};
      addend = '0;
      unique case (window)
         3'b001, 3'b010: addend = mExt;
         3'b011:         addend = mExt <<< 1;
         3'b100:         addend = -(mExt <<< 1);
         3'b101, 3'b110: addend = -mExt;
         default:        addend = '0;
      endcase
      sum         = upper + addend;
      partialNext = {{2{sum[WIDTH+1]}}, sum, partial[WIDTH-2:0]};
   end

endmodule

// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply (radix-4 Booth) / divide (restoring) unit
// with a fixed 17-cycle multiply and 33-cycle divide latency.
module multdiv
   import multdiv_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             data_busy,
   output state_t           dbgState
);

   // Handshake: a one-cycle ctrl_MULT/ctrl_DIV pulse is accepted in any cycle
   // (restarting any op in flight); completion is a one-cycle data_resultRDY
   // pulse, with data_result/data_exception valid then and held afterwards.

   state_t           state, stateNext;
   logic [4:0]       counter, counterNext;
   logic             startMul, startDiv, start;

   logic [2*WIDTH+2:0] acc, accNext;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   rem, quo, divisor;
   logic               isDiv, negQuo, divZero, divOvf;

   logic [WIDTH:0]     divShifted;
   logic               divFits;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   finalResult;
   logic               finalExc;

   assign startMul = ctrl_MULT;
   assign startDiv = ctrl_DIV & ~ctrl_MULT;
   assign start    = startMul | startDiv;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         counter <= '0;
      end else begin
         state   <= stateNext;
         counter <= counterNext;
      end
   end

   always_comb begin
      stateNext   = state;
      counterNext = counter;
      unique case (state)
         MUL: begin
            counterNext = counter + 5'd1;
            if (counter == 5'(MUL_ITERS - 1)) begin
               stateNext   = DONE;
               counterNext = '0;
            end
         end
         DIV: begin
            counterNext = counter + 5'd1;
            if (counter == 5'(DIV_ITERS - 1)) begin
               stateNext   = DONE;
               counterNext = '0;
            end
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
      if (startMul) begin
         stateNext   = MUL;
         counterNext = '0;
      end else if (startDiv) begin
         stateNext   = DIV;
         counterNext = '0;
      end
   end

   booth_step uBooth (
      .window      (acc[2:0]),
      .mcand       (mcand),
      .partial     (acc[2*WIDTH+2:2]),
      .partialNext (accNext)
   );

   always_comb begin
      divShifted  = {rem, quo[WIDTH-1]};
      divFits     = divShifted >= {1'b0, divisor};
      product     = acc[2*WIDTH:1];
      finalResult = product[WIDTH-1:0];
      finalExc    = !((&product[2*WIDTH-1:WIDTH-1]) || !(|product[2*WIDTH-1:WIDTH-1]));
      if (isDiv) begin
         finalExc    = divZero | divOvf;
         finalResult = negQuo ? -quo : quo;
         if (divZero)
            finalResult = '0;
         else if (divOvf)
            finalResult = INT_MIN;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc            <= '0;
         mcand          <= '0;
         rem            <= '0;
         quo            <= '0;
         divisor        <= '0;
         isDiv          <= 1'b0;
         negQuo         <= 1'b0;
         divZero        <= 1'b0;
         divOvf         <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= (state == DONE);
         if (state == DONE) begin
            data_result    <= finalResult;
            data_exception <= finalExc;
         end
         if (start) begin
            acc     <= {{(WIDTH+2){1'b0}}, data_operandB, 1'b0};
            mcand   <= data_operandA;
            rem     <= '0;
            quo     <= magnitude(data_operandA);
            divisor <= magnitude(data_operandB);
            isDiv   <= startDiv;
            negQuo  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            divZero <= (data_operandB == '0);
            divOvf  <= (data_operandA == INT_MIN) && (&data_operandB);
         end else if (state == MUL) begin
            acc <= accNext;
         end else if (state == DIV) begin
            rem <= divFits ? WIDTH'(divShifted - {1'b0, divisor}) : divShifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], divFits};
         end
      end
   end

   assign data_busy = (state != IDLE);
   assign dbgState  = state;

endmodule
